aes256_axil_regs: RTL and testbench
===================================

Name: aes256_axil_regs

Overview:
AXI4-Lite slave register bank that sits directly downstream of the AXI master (VIP in simulation, PS in hardware) inside the aes256_ip wrapper. It is the upstream feed of the AES-256 core.
- Holds the 256-bit key, the 128-bit plaintext and the control bits, and issues a single-cycle start pulse to the core.
- Captures the 128-bit ciphertext and the done event and exposes them as status and readback registers plus a level interrupt.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 7, byte address width (register map spans 0x00-0x4C)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  7  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID/AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID/WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID/BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  7  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID/ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID/RREADY  out/in  1  read data handshake
key_o  out  256  key to core; KEY0 maps to [255:224]
pt_o  out  128  plaintext to core; PT0 maps to [127:96]
start_o  out  1  one-cycle start pulse
ct_i  in  128  ciphertext from core; sampled when done_i=1
done_i  in  1  one-cycle completion pulse
irq_o  out  1  registered interrupt level

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs are 0, including every READY/VALID, start_o, irq_o, the KEY/PT/CT registers, CTRL and STATUS.
- Register map (byte offsets):
  - 0x00-0x1C KEY0-7, RW
  - 0x20-0x2C PT0-3, RW
  - 0x30 CTRL: bit0 START (write-1 action, reads 0), bit1 IRQ_EN (RW)
  - 0x34 STATUS: bit0 BUSY (RO), bit1 DONE (W1C)
  - 0x40-0x4C CT0-3, RO
  - Unused bits read 0.
- Write channel:
  - AWREADY and WREADY assert together for exactly one cycle when AWVALID & WVALID & !BVALID.
  - Register update happens on that cycle, honouring WSTRB per byte.
  - BVALID rises the next cycle and holds until BREADY. No second write is accepted while BVALID=1.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RDATA/RRESP are registered and RVALID rises the next cycle, holding with stable data until RREADY.
  - Read and write channels run independently and may complete in the same cycle.
- Responses:
  - Unmapped address: write ignored, read returns 0, response SLVERR (2'b10).
  - Write to a CT register: SLVERR.
  - Write to KEY/PT while BUSY=1: ignored, SLVERR.
  - Everything else: OKAY.
- Start:
  - Writing CTRL with START=1 (byte 0 strobed) while BUSY=0 makes start_o high the next cycle for one cycle, sets BUSY and clears DONE.
  - START while BUSY=1 is ignored, response OKAY.
- Done:
  - done_i while BUSY=1 loads CT from ct_i, clears BUSY and sets DONE, all in the same edge.
  - done_i while BUSY=0 is ignored.
- Simultaneous events:
  - done_i in the same cycle as a DONE W1C: set wins.
  - A CT read in the same cycle as the done_i capture returns the old value.
- Interrupt: irq_o = register(DONE & IRQ_EN), one cycle latency.
- Reset mid-operation: everything returns to reset values and any in-flight AXI transaction is dropped.

Decomposition:
- Package aes256_ip_pkg:
  - register offset localparams (KEY_BASE, PT_BASE, CTRL_OFS, STATUS_OFS, CT_BASE)
  - CTRL/STATUS bit indices
  - AXI resp constants (RESP_OKAY, RESP_SLVERR)
- Single module; no sub-module. The read mux and decode are inline always blocks.

Test Plan:
- FIPS-197 path with a stub core:
  - Stimulus: write KEY0-7 = 00010203..1c1d1e1f, PT0-3 = 00112233..ccddeeff; write CTRL=0x1. The stub returns done_i with ct_i=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
  - Expect: start_o pulses exactly once; STATUS reads 0x1 then 0x2; CT0-3 read 8ea2b7ca, 516745bf, eafc4990, 4b496089; all responses OKAY.
- Byte strobes: write KEY3=0xAABBCCDD with WSTRB=0b0101 over a prior value of 0 -> reads 0x00BB00DD; key_o[159:128] matches.
- Busy protection: during busy, write PT1=0xFFFFFFFF -> BRESP=SLVERR and PT1 unchanged; a second START produces no extra start_o pulse.
- Interrupt and W1C:
  - Set IRQ_EN and complete an operation -> irq_o=1 one cycle after DONE sets.
  - Write STATUS=0x2 -> DONE=0 and irq_o falls.
  - W1C coincident with done_i -> DONE stays 1.
- Backpressure and errors:
  - Hold BREADY/RREADY low for 10 cycles -> BVALID/RVALID and RDATA stay stable and no new AW/AR is accepted.
  - Read 0x38 -> RDATA=0 with SLVERR.
  - Write CT0 -> SLVERR.
- Reset mid-operation: assert ARESETN low while BUSY=1 with RVALID pending -> all outputs are 0 asynchronously, and KEY0 reads 0 after release.

Source files
------------

// File: rtl/aes256_ip_pkg.sv
// Shared constants for the AES-256 IP register bank: register map, control and
// status bit positions, AXI response codes, plus address decode and strobe helpers.
package aes256_ip_pkg;

  localparam logic [6:0] KEY_BASE   = 7'h00;
  localparam logic [6:0] PT_BASE    = 7'h20;
  localparam logic [6:0] CTRL_OFS   = 7'h30;
  localparam logic [6:0] STATUS_OFS = 7'h34;
  localparam logic [6:0] CT_BASE    = 7'h40;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_KEY,
    REG_PT,
    REG_CTRL,
    REG_STATUS,
    REG_CT,
    REG_NONE
  } reg_sel_e;

  // Byte offset to register group; the low two address bits never select a register.
  function automatic reg_sel_e decode(input logic [6:0] addr);
    if ((addr & 7'h60) == KEY_BASE)        return REG_KEY;
    else if ((addr & 7'h70) == PT_BASE)    return REG_PT;
    else if ((addr & 7'h7C) == CTRL_OFS)   return REG_CTRL;
    else if ((addr & 7'h7C) == STATUS_OFS) return REG_STATUS;
    else if ((addr & 7'h70) == CT_BASE)    return REG_CT;
    else                                   return REG_NONE;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes256_axil_regs.sv
// AXI4-Lite register bank feeding the AES-256 core: key/plaintext/control out,
// ciphertext/done capture in, with a level interrupt on completion.
module aes256_axil_regs
  import aes256_ip_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [255:0]                    key_o,
  output logic [127:0]                    pt_o,
  output logic                            start_o,
  input  logic [127:0]                    ct_i,
  input  logic                            done_i,
  output logic                            irq_o
);

  logic        awready_q, arready_q, bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] key_q [8];
  logic [31:0] pt_q  [4];
  logic [31:0] ct_q  [4];
  logic        irq_en_q, busy_q, done_q, start_q, irq_q;

  logic        wr_hs, rd_hs;
  reg_sel_e    wr_sel, rd_sel;
  logic [1:0]  bresp_d, rresp_d;
  logic [31:0] rdata_d;
  logic        unused_prot;

  // Handshake: READY is a one-cycle registered pulse raised only while the
  // response channel is idle; a transfer happens on the edge where READY and
  // VALID are both high, and the response VALID then holds until its READY.
  assign wr_hs  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs  = arready_q & S_AXI_ARVALID;
  assign wr_sel = decode(S_AXI_AWADDR);
  assign rd_sel = decode(S_AXI_ARADDR);
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  always_comb begin
    bresp_d = RESP_OKAY;
    case (wr_sel)
      REG_KEY, REG_PT: if (busy_q) bresp_d = RESP_SLVERR;
      REG_CT, REG_NONE: bresp_d = RESP_SLVERR;
      default: ;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (rd_sel)
      REG_KEY:    rdata_d = key_q[S_AXI_ARADDR[4:2]];
      REG_PT:     rdata_d = pt_q[S_AXI_ARADDR[3:2]];
      REG_CTRL:   rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      REG_STATUS: begin
        rdata_d[STATUS_BUSY_BIT] = busy_q;
        rdata_d[STATUS_DONE_BIT] = done_q;
      end
      REG_CT:     rdata_d = ct_q[S_AXI_ARADDR[3:2]];
      default:    rresp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rresp_d;
        rdata_q  <= rdata_d;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 8; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        pt_q[i] <= '0;
        ct_q[i] <= '0;
      end
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      irq_q   <= done_q & irq_en_q;
      if (wr_hs) begin
        case (wr_sel)
          REG_KEY: if (!busy_q)
            key_q[S_AXI_AWADDR[4:2]] <= apply_strb(key_q[S_AXI_AWADDR[4:2]], S_AXI_WDATA, S_AXI_WSTRB);
          REG_PT: if (!busy_q)
            pt_q[S_AXI_AWADDR[3:2]] <= apply_strb(pt_q[S_AXI_AWADDR[3:2]], S_AXI_WDATA, S_AXI_WSTRB);
          REG_CTRL: if (S_AXI_WSTRB[0]) begin
            irq_en_q <= S_AXI_WDATA[CTRL_IRQ_EN_BIT];
            if (S_AXI_WDATA[CTRL_START_BIT] && !busy_q) begin
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          REG_STATUS: if (S_AXI_WSTRB[0] && S_AXI_WDATA[STATUS_DONE_BIT]) done_q <= 1'b0;
          default: ;
        endcase
      end
      // Placed after the W1C so a coincident completion keeps DONE set.
      if (done_i && busy_q) begin
        for (int i = 0; i < 4; i++) ct_q[i] <= ct_i[127-32*i -: 32];
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_key
    assign key_o[255-32*g -: 32] = key_q[g];
  end
  for (genvar g = 0; g < 4; g++) begin : g_pt
    assign pt_o[127-32*g -: 32] = pt_q[g];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign start_o       = start_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_aes256_axil_regs.sv
// Bench for aes256_axil_regs: AXI-Lite driver tasks, a stub AES core and a
// response scoreboard checked against constants from the register map.
module tb_aes256_axil_regs;
  import aes256_ip_pkg::*;

  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ALT_CT  = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] key_o;
  logic [127:0] pt_o;
  logic         start_o, irq_o, done_i;
  logic [127:0] ct_i = FIPS_CT;

  int checks = 0;
  int errors = 0;
  logic [1:0]  wr_exp_q[$];
  logic [33:0] rd_exp_q[$];

  int   start_cnt = 0;
  int   stub_cnt  = 0;
  logic stub_en   = 1'b1;
  logic stub_done = 1'b0;
  logic man_done  = 1'b0;
  assign done_i = stub_done | man_done;

  aes256_axil_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .key_o(key_o), .pt_o(pt_o), .start_o(start_o), .ct_i(ct_i), .done_i(done_i), .irq_o(irq_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // ---------------- stub AES core: done 14 cycles after start ----------------
  always begin
    @(posedge clk); #1;
    stub_done = 1'b0;
    if (!rst_n) stub_cnt = 0;
    else if (start_o) begin
      start_cnt++;
      if (stub_en) stub_cnt = 14;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) stub_done = 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event did not occur within bound", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input string name);
    int n;
    logic [1:0] e;
    wr_exp_q.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    e = wr_exp_q.pop_front();
    if (!bvalid) timeout_fail({name, " bvalid"});
    else chk({name, " bresp"}, 256'(bresp), 256'(e));
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [6:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input string name);
    int n;
    logic [33:0] e;
    rd_exp_q.push_back({er, ed});
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    e = rd_exp_q.pop_front();
    if (!rvalid) timeout_fail({name, " rvalid"});
    else chk(name, 256'({rresp, rdata}), 256'(e));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done_i && n < 100);
    if (!done_i) timeout_fail(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    string       name;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   n;
    logic ok_w, ok_r;
    logic [1:0]  eb;
    logic [33:0] er;

    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 7'(4*i), {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 4'hf, RESP_OKAY, $sformatf("wr KEY%0d", i)});
    tbl.push_back('{1'b1, PT_BASE + 7'h0, 32'h00112233, 4'hf, RESP_OKAY, "wr PT0"});
    tbl.push_back('{1'b1, PT_BASE + 7'h4, 32'h44556677, 4'hf, RESP_OKAY, "wr PT1"});
    tbl.push_back('{1'b1, PT_BASE + 7'h8, 32'h8899aabb, 4'hf, RESP_OKAY, "wr PT2"});
    tbl.push_back('{1'b1, PT_BASE + 7'hC, 32'hccddeeff, 4'hf, RESP_OKAY, "wr PT3"});
    tbl.push_back('{1'b0, KEY_BASE,        32'h00010203, 4'h0, RESP_OKAY, "rd KEY0"});
    tbl.push_back('{1'b0, KEY_BASE + 7'h1C, 32'h1c1d1e1f, 4'h0, RESP_OKAY, "rd KEY7"});
    tbl.push_back('{1'b0, PT_BASE + 7'hC,  32'hccddeeff, 4'h0, RESP_OKAY, "rd PT3"});
    tbl.push_back('{1'b0, CTRL_OFS,        32'h0, 4'h0, RESP_OKAY, "rd CTRL idle"});
    tbl.push_back('{1'b0, STATUS_OFS,      32'h0, 4'h0, RESP_OKAY, "rd STATUS idle"});
    tbl.push_back('{1'b0, 7'h38,           32'h0, 4'h0, RESP_SLVERR, "rd 0x38 unmapped"});
    tbl.push_back('{1'b0, 7'h50,           32'h0, 4'h0, RESP_SLVERR, "rd 0x50 unmapped"});
    tbl.push_back('{1'b1, CT_BASE,         32'hdeadbeef, 4'hf, RESP_SLVERR, "wr CT0"});
    tbl.push_back('{1'b0, CT_BASE,         32'h0, 4'h0, RESP_OKAY, "rd CT0 after wr"});
    tbl.push_back('{1'b1, 7'h3C,           32'hffffffff, 4'hf, RESP_SLVERR, "wr 0x3C unmapped"});

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("reset axi outputs", 256'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}), '0);
    chk("reset core outputs", 256'({start_o, irq_o, pt_o}), '0);
    chk("reset key_o", key_o, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, tbl[i].name);
      else           axi_read(tbl[i].addr, tbl[i].data, tbl[i].resp, tbl[i].name);
    end
    chk("key_o FIPS", key_o, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("pt_o FIPS", 256'(pt_o), 256'(128'h00112233445566778899aabbccddeeff));

    // ---------------- FIPS-197 operation ----------------
    axi_write(CTRL_OFS, 32'h1, 4'hf, RESP_OKAY, "wr CTRL start");
    axi_read(STATUS_OFS, 32'h1, RESP_OKAY, "STATUS busy");
    wait_done("fips done");
    @(posedge clk); #1;
    axi_read(STATUS_OFS, 32'h2, RESP_OKAY, "STATUS done");
    axi_read(CT_BASE + 7'h0, 32'h8ea2b7ca, RESP_OKAY, "rd CT0");
    axi_read(CT_BASE + 7'h4, 32'h516745bf, RESP_OKAY, "rd CT1");
    axi_read(CT_BASE + 7'h8, 32'heafc4990, RESP_OKAY, "rd CT2");
    axi_read(CT_BASE + 7'hC, 32'h4b496089, RESP_OKAY, "rd CT3");
    chk("start pulses after fips", 256'(start_cnt), 256'(1));

    // ---------------- byte strobes ----------------
    axi_write(KEY_BASE + 7'hC, 32'h0, 4'hf, RESP_OKAY, "wr KEY3 clear");
    axi_write(KEY_BASE + 7'hC, 32'hAABBCCDD, 4'b0101, RESP_OKAY, "wr KEY3 strobed");
    axi_read(KEY_BASE + 7'hC, 32'h00BB00DD, RESP_OKAY, "rd KEY3 strobed");
    chk("key_o KEY3 slice", 256'(key_o[159:128]), 256'(32'h00BB00DD));

    // ---------------- interrupt and W1C ----------------
    axi_write(CTRL_OFS, 32'h2, 4'hf, RESP_OKAY, "wr CTRL irq_en");
    axi_read(CTRL_OFS, 32'h2, RESP_OKAY, "rd CTRL irq_en");
    axi_write(CTRL_OFS, 32'h3, 4'hf, RESP_OKAY, "wr CTRL start irq");
    wait_done("irq op done");
    @(negedge clk);
    chk("irq low as DONE sets", 256'(irq_o), 256'(0));
    @(negedge clk);
    chk("irq high one cycle later", 256'(irq_o), 256'(1));
    axi_write(STATUS_OFS, 32'h2, 4'hf, RESP_OKAY, "wr STATUS W1C");
    chk("irq falls after W1C", 256'(irq_o), 256'(0));
    axi_read(STATUS_OFS, 32'h0, RESP_OKAY, "STATUS after W1C");

    // ---------------- busy protection ----------------
    stub_en = 1'b0;
    ct_i = ALT_CT;
    axi_write(CTRL_OFS, 32'h3, 4'hf, RESP_OKAY, "wr CTRL start hold");
    axi_write(PT_BASE + 7'h4, 32'hffffffff, 4'hf, RESP_SLVERR, "wr PT1 busy");
    axi_read(PT_BASE + 7'h4, 32'h44556677, RESP_OKAY, "rd PT1 unchanged");
    axi_write(CTRL_OFS, 32'h3, 4'hf, RESP_OKAY, "wr CTRL start busy");
    repeat (3) @(posedge clk);
    #1;
    chk("start pulses after busy start", 256'(start_cnt), 256'(3));
    axi_read(STATUS_OFS, 32'h1, RESP_OKAY, "STATUS busy hold");

    // ---------------- done_i coincident with W1C and CT0 read ----------------
    wr_exp_q.push_back(RESP_OKAY);
    rd_exp_q.push_back({RESP_OKAY, 32'h8ea2b7ca});
    awaddr = STATUS_OFS; wdata = 32'h2; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
    araddr = CT_BASE; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && arready) && n < 50);
    if (!(awready && arready)) timeout_fail("coincident ready");
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    eb = wr_exp_q.pop_front();
    er = rd_exp_q.pop_front();
    chk("coincident valids", 256'({bvalid, rvalid}), 256'(2'b11));
    chk("coincident bresp", 256'(bresp), 256'(eb));
    chk("CT0 read at capture is old", 256'({rresp, rdata}), 256'(er));
    @(posedge clk); #1;
    axi_read(STATUS_OFS, 32'h2, RESP_OKAY, "DONE set wins over W1C");
    axi_read(CT_BASE, 32'h01234567, RESP_OKAY, "rd CT0 new");
    chk("irq after coincident done", 256'(irq_o), 256'(1));
    stub_en = 1'b1;

    // ---------------- backpressure ----------------
    bready = 1'b0; rready = 1'b0;
    wr_exp_q.push_back(RESP_OKAY);
    rd_exp_q.push_back({RESP_OKAY, 32'h00010203});
    awaddr = PT_BASE + 7'h8; wdata = 32'h12345678; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
    araddr = KEY_BASE; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && arready) && n < 50);
    if (!(awready && arready)) timeout_fail("backpressure ready");
    @(posedge clk); #1;
    awaddr = PT_BASE + 7'hC; wdata = 32'hdeadbeef; araddr = KEY_BASE + 7'h1C;
    eb = wr_exp_q.pop_front();
    er = rd_exp_q.pop_front();
    ok_w = 1'b1; ok_r = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bvalid || bresp !== eb || awready || wready) ok_w = 1'b0;
      if (!rvalid || {rresp, rdata} !== er || arready) ok_r = 1'b0;
    end
    chk("bp write held stable", 256'(ok_w), 256'(1));
    chk("bp read held stable", 256'(ok_r), 256'(1));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp channels drained", 256'({bvalid, rvalid}), 256'(0));
    @(posedge clk); #1;
    axi_read(PT_BASE + 7'h8, 32'h12345678, RESP_OKAY, "rd PT2 after bp");
    axi_read(PT_BASE + 7'hC, 32'hccddeeff, RESP_OKAY, "rd PT3 not overwritten");

    // ---------------- reset mid-operation ----------------
    axi_write(CTRL_OFS, 32'h1, 4'hf, RESP_OKAY, "wr CTRL start pre-reset");
    rready = 1'b0;
    araddr = KEY_BASE; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid pending pre-reset", 256'({rvalid, rdata}), 256'({1'b1, 32'h00010203}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset axi outputs", 256'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}), '0);
    chk("async reset core outputs", 256'({start_o, irq_o, pt_o}), '0);
    chk("async reset key_o", key_o, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    axi_read(KEY_BASE, 32'h0, RESP_OKAY, "KEY0 after reset");
    axi_read(STATUS_OFS, 32'h0, RESP_OKAY, "STATUS after reset");
    axi_read(CTRL_OFS, 32'h0, RESP_OKAY, "CTRL after reset");
    chk("scoreboard queues empty", 256'(wr_exp_q.size() + rd_exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
